sccb_target: RTL and testbench

SCCB_TARGET -- requirements
Module: sccb_target

---
 rtl/sccb_pkg.sv | 23 ++
 rtl/sccb_sync_edge.sv | 24 ++
 rtl/sccb_target.sv | 187 ++++++++++++++++++
 tb/tb_sccb_target.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target: FSM state encoding,
// default device ID and the SIO_D level a target drives in an ACK slot.
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ID,
        ID_ACK,
        ADDRH,
        ADDRH_ACK,
        ADDRL,
        ADDRL_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_NA,
        IGNORE
    } sccb_state_e;

    localparam logic [6:0] SCCB_DEV_ID_DEFAULT = 7'h3C;
    localparam logic       SCCB_ACK_LVL        = 1'b0;

endpackage

// File: rtl/sccb_sync_edge.sv
// Two-flop synchronizer for one asynchronous bus line plus one-clk rise/fall
// pulses. Resets to 1 so an idle (pulled-up) bus produces no edges.
module sccb_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // [1:0] synchronizer stages, [2] previous synchronized value
    logic [2:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rstn) r_sync <= 3'b111;
        else       r_sync <= {r_sync[1:0], i_async};
    end

    assign o_level = r_sync[1];
    assign o_rise  =  r_sync[1] & ~r_sync[2];
    assign o_fall  = ~r_sync[1] &  r_sync[2];

endmodule

// File: rtl/sccb_target.sv
// SCCB target mapping bus writes/reads onto a 16-bit-address register port.
// Define SCCB_TARGET_AUTOINC_EN to step reg_addr after every written/read byte.
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID = SCCB_DEV_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sccb_clk,
    input  logic        sccb_data_in,
    output logic        sccb_data_out,
    output logic        sccb_data_en,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    logic        w_scl, w_scl_rise, w_scl_fall;
    logic        w_sda, w_sda_rise, w_sda_fall;
    logic        w_start, w_stop, w_last_bit, w_ack_done, w_busy_nxt;
    logic [7:0]  w_byte;
    sccb_state_e r_state, w_state_nxt;

    logic [2:0]  r_bitcnt;
    logic [6:0]  r_shift;
    logic        r_rw, r_ack_drv, r_busy;
    logic        r_sda_en, r_sda_out, r_we, r_re;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;

    sccb_sync_edge u_sync_scl (
        .clk    (clk),
        .rstn   (rstn),
        .i_async(sccb_clk),
        .o_level(w_scl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

    sccb_sync_edge u_sync_sda (
        .clk    (clk),
        .rstn   (rstn),
        .i_async(sccb_data_in),
        .o_level(w_sda),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    assign w_start    = w_sda_fall & w_scl;
    assign w_stop     = w_sda_rise & w_scl;
    assign w_byte     = {r_shift, w_sda};
    assign w_last_bit = w_scl_rise && (r_bitcnt == 3'd7);
    // ACK slot ends on the second SIO_C fall seen in an ACK state
    assign w_ack_done = w_scl_fall && r_ack_drv;

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = IDLE;
        end else if (w_start) begin
            w_state_nxt = ID;
        end else begin
            case (r_state)
                ID:        if (w_last_bit) w_state_nxt = (w_byte[7:1] == DEV_ID) ? ID_ACK : IGNORE;
                ID_ACK:    if (w_ack_done) w_state_nxt = r_rw ? RDATA : ADDRH;
                ADDRH:     if (w_last_bit) w_state_nxt = ADDRH_ACK;
                ADDRH_ACK: if (w_ack_done) w_state_nxt = ADDRL;
                ADDRL:     if (w_last_bit) w_state_nxt = ADDRL_ACK;
                ADDRL_ACK: if (w_ack_done) w_state_nxt = WDATA;
                WDATA:     if (w_last_bit) w_state_nxt = WDATA_ACK;
                WDATA_ACK: if (w_ack_done) w_state_nxt = WDATA;
                RDATA:     if (w_last_bit) w_state_nxt = RDATA_NA;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    // busy survives a repeated START only if the target was already addressed
    always_comb begin
        w_busy_nxt = 1'b1;
        if (w_state_nxt inside {IDLE, IGNORE}) w_busy_nxt = 1'b0;
        else if (w_state_nxt == ID)            w_busy_nxt = r_busy;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_ack_drv <= 1'b0;
            r_busy    <= 1'b0;
            r_sda_en  <= 1'b0;
            r_sda_out <= 1'b0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            if (w_start || w_stop) begin
                r_bitcnt  <= '0;
                r_ack_drv <= 1'b0;
                r_sda_en  <= 1'b0;
                r_sda_out <= 1'b0;
            end else begin
                case (r_state)
                    ID, ADDRH, ADDRL, WDATA: begin
                        r_sda_en <= 1'b0;
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                if (r_state == ID)         r_rw          <= w_byte[0];
                                else if (r_state == ADDRH) r_addr[15:8]  <= w_byte;
                                else if (r_state == ADDRL) r_addr[7:0]   <= w_byte;
                                else begin
                                    r_wdata <= w_byte;
                                    r_we    <= 1'b1;
                                end
                            end
                        end
                    end
                    ID_ACK, ADDRH_ACK, ADDRL_ACK, WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                r_ack_drv <= 1'b1;
                                r_sda_en  <= 1'b1;
                                r_sda_out <= SCCB_ACK_LVL;
                            end else begin
                                r_ack_drv <= 1'b0;
                                r_bitcnt  <= '0;
                                // read: keep SIO_D driven, bit7 replaces the ACK level once fetched
                                if (r_state == ID_ACK && r_rw) r_re     <= 1'b1;
                                else                           r_sda_en <= 1'b0;
                            end
                        end
                    end
                    RDATA: begin
                        if (r_re) begin
                            r_shift   <= reg_rdata[6:0];
                            r_sda_out <= reg_rdata[7];
                        end else if (w_scl_fall) begin
                            r_shift   <= {r_shift[5:0], 1'b0};
                            r_sda_out <= r_shift[6];
                        end
                        if (w_scl_rise) r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    RDATA_NA: begin
                        // initiator owns SIO_D for NA; the target stays off until STOP
                        if (w_scl_fall) begin
                            r_sda_en  <= 1'b0;
                            r_sda_out <= 1'b0;
                        end
                    end
                    default: begin
                        r_sda_en  <= 1'b0;
                        r_sda_out <= 1'b0;
                    end
                endcase
            end
`ifdef SCCB_TARGET_AUTOINC_EN
            if (r_we || (r_state == RDATA && w_last_bit && !w_start && !w_stop))
                r_addr <= r_addr + 16'd1;
`endif
        end
    end

    assign sccb_data_out = r_sda_out;
    assign sccb_data_en  = r_sda_en;
    assign reg_addr      = r_addr;
    assign reg_wdata     = r_wdata;
    assign reg_we        = r_we;
    assign reg_re        = r_re;
    assign busy          = r_busy;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB initiator plus a transaction-level
// model of expected register writes, read addresses and final reg_addr.
`timescale 1ns/1ps
module tb_sccb_target;
    import sccb_pkg::*;

    localparam int H = 12;  // clk cycles per SIO_C half period
`ifdef SCCB_TARGET_AUTOINC_EN
    localparam int AINC = 1;
`else
    localparam int AINC = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_bus;
    logic        sccb_data_out, sccb_data_en, reg_we, reg_re, busy;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  rd_val = 8'h00;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [23:0] we_q[$];
    logic [15:0] re_q[$];
    logic        en_any = 1'b0;
    logic        busy_any = 1'b0;
    logic [15:0] m_addr = 16'h0000;
    logic [7:0]  wbuf [4];

    always #5 clk = ~clk;

    assign sda_bus = m_sda & (sccb_data_en ? sccb_data_out : 1'b1);

    sccb_target #(.DEV_ID(7'h3C)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sccb_clk     (m_scl),
        .sccb_data_in (sda_bus),
        .sccb_data_out(sccb_data_out),
        .sccb_data_en (sccb_data_en),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (rd_val),
        .busy         (busy)
    );

    always @(negedge clk) begin
        if (reg_we) we_q.push_back({reg_addr, reg_wdata});
        if (reg_re) re_q.push_back(reg_addr);
        if (sccb_data_en) en_any = 1'b1;
        if (busy) busy_any = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wclk(H/2);
        m_scl = 1'b1; wclk(H);
        m_sda = 1'b0; wclk(H);
        m_scl = 1'b0; wclk(H/2);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wclk(H/2);
        m_scl = 1'b1; wclk(H);
        m_sda = 1'b1; wclk(H);
    endtask

    task automatic bus_bit(input logic b, output logic seen, output logic drv);
        m_sda = b;    wclk(H/2);
        m_scl = 1'b1; wclk(H/2);
        @(negedge clk);
        seen = sda_bus;
        drv  = sccb_data_en;
        wclk(H/2);
        m_scl = 1'b0; wclk(H/2);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked, output logic drove);
        logic s, d;
        drove = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(b[i], s, d);
            drove = drove | d;
        end
        bus_bit(1'b1, s, d);
        acked = (s == 1'b0) && d;
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic drove_all, output logic na_rel);
        logic s, d;
        drove_all = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s, d);
            b[i] = s;
            drove_all = drove_all & d;
        end
        bus_bit(1'b1, s, d);
        na_rel = !d && s;
    endtask

    task automatic txn_write(input string tag, input logic [15:0] addr, input int nb, input bit do_stop);
        logic a, d;
        logic [15:0] ea;
        we_q.delete();
        busy_any = 1'b0;
        bus_start();
        send_byte(8'h78, a, d);
        check({tag, "_id"}, {a, d}, 2'b10);
        send_byte(addr[15:8], a, d);
        check({tag, "_ah"}, {a, d}, 2'b10);
        send_byte(addr[7:0], a, d);
        check({tag, "_al"}, {a, d}, 2'b10);
        for (int i = 0; i < nb; i++) begin
            send_byte(wbuf[i], a, d);
            check($sformatf("%s_d%0d", tag, i), {a, d}, 2'b10);
        end
        if (do_stop) bus_stop();
        check({tag, "_nwe"}, we_q.size(), nb);
        for (int i = 0; i < nb && i < we_q.size(); i++) begin
            ea = addr + 16'(AINC * i);
            check($sformatf("%s_we%0d", tag, i), we_q[i], {ea, wbuf[i]});
        end
        m_addr = addr + 16'(AINC * nb);
        check({tag, "_addr"}, reg_addr, m_addr);
        check({tag, "_busyhi"}, busy_any, 1'b1);
        if (do_stop) check({tag, "_busylo"}, busy, 1'b0);
    endtask

    task automatic txn_read(input string tag, input logic [7:0] val);
        logic a, d, dr, na;
        logic [7:0] b;
        rd_val = val;
        re_q.delete();
        bus_start();
        send_byte(8'h79, a, d);
        check({tag, "_id"}, {a, d}, 2'b10);
        recv_byte(b, dr, na);
        bus_stop();
        check({tag, "_data"}, b, val);
        check({tag, "_drv"}, dr, 1'b1);
        check({tag, "_na"}, na, 1'b1);
        check({tag, "_nre"}, re_q.size(), 1);
        if (re_q.size() > 0) check({tag, "_raddr"}, re_q[0], m_addr);
        m_addr = m_addr + 16'(AINC);
        check({tag, "_addr"}, reg_addr, m_addr);
        check({tag, "_busylo"}, busy, 1'b0);
    endtask

    task automatic txn_foreign(input string tag, input logic [7:0] id);
        logic a, d;
        en_any = 1'b0;
        busy_any = 1'b0;
        we_q.delete();
        bus_start();
        send_byte(id, a, d);
        check({tag, "_noack"}, {a, d}, 2'b00);
        send_byte(8'($urandom), a, d);
        send_byte(8'($urandom), a, d);
        bus_stop();
        check({tag, "_en"}, en_any, 1'b0);
        check({tag, "_busy"}, busy_any, 1'b0);
        check({tag, "_nwe"}, we_q.size(), 0);
        check({tag, "_addr"}, reg_addr, m_addr);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, d, s;
        logic [7:0] fid;

        // reset state
        wclk(4);
        @(negedge clk);
        check("rst_en", sccb_data_en, 1'b0);
        check("rst_out", sccb_data_out, 1'b0);
        check("rst_we", reg_we, 1'b0);
        check("rst_re", reg_re, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", reg_addr, 16'h0000);
        check("rst_wdata", reg_wdata, 8'h00);
        rstn = 1'b1;
        wclk(4);

        // single write 0x82 to 0x3008
        wbuf[0] = 8'h82;
        txn_write("w3008", 16'h3008, 1, 1'b1);

        // set address 0x300A, STOP, then read it back
        txn_write("wa300a", 16'h300A, 0, 1'b1);
        txn_read("r300a", 8'h56);

        // foreign device ID
        txn_foreign("id42", 8'h42);

        // STOP after 4 data bits
        we_q.delete();
        bus_start();
        send_byte(8'h78, a, d);
        send_byte(8'h12, a, d);
        send_byte(8'h34, a, d);
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s, d);
        bus_stop();
        m_addr = 16'h1234;
        check("part_nwe", we_q.size(), 0);
        check("part_state", 32'(dut.r_state), 32'(IDLE));
        check("part_busy", busy, 1'b0);
        check("part_addr", reg_addr, m_addr);

        // two bytes at 0xFFFF: wraps to 0x0000 only with auto-increment
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        txn_write("wffff", 16'hFFFF, 2, 1'b1);

        // reset while the target is shifting out read data
        rd_val = 8'hA5;
        bus_start();
        send_byte(8'h79, a, d);
        check("rrst_id", {a, d}, 2'b10);
        for (int i = 0; i < 3; i++) bus_bit(1'b1, s, d);
        @(negedge clk);
        check("rrst_pre_en", sccb_data_en, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        check("rrst_en", sccb_data_en, 1'b0);
        check("rrst_busy", busy, 1'b0);
        rstn = 1'b1;
        en_any = 1'b0;
        we_q.delete();
        for (int i = 0; i < 6; i++) bus_bit(1'b1, s, d);
        bus_stop();
        m_addr = 16'h0000;
        check("rrst_quiet", en_any, 1'b0);
        check("rrst_nwe", we_q.size(), 0);
        check("rrst_addr", reg_addr, m_addr);
        wbuf[0] = 8'($urandom);
        txn_write("post_rst", 16'($urandom), 1, 1'b1);

        // randomized transactions of every kind
        for (int t = 0; t < 8; t++) begin
            case (t % 4)
                0: begin
                    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                    txn_write($sformatf("rw%0d", t), 16'($urandom), $urandom_range(1, 3), 1'b1);
                end
                1: begin
                    txn_write($sformatf("ra%0d", t), 16'($urandom), 0, 1'b1);
                    txn_read($sformatf("rr%0d", t), 8'($urandom));
                end
                2: begin
                    txn_write($sformatf("sa%0d", t), 16'($urandom), 0, 1'b0);
                    txn_read($sformatf("sr%0d", t), 8'($urandom));
                end
                default: begin
                    fid = 8'($urandom);
                    if (fid[7:1] == 7'h3C) fid = fid ^ 8'h80;
                    txn_foreign($sformatf("rf%0d", t), fid);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
